seq_grid_mapper: RTL and testbench
==================================

// Module: seq_grid_mapper
// PURPOSE
//  Pixel colour generator for the step-sequencer grid display; successor to the single-ball mapper.
//  Draws NUM_TRACKS x NUM_STEPS cells with playhead column, edit cursor, per-track hit flash and gradient background.
//  Sits between the VGA timing generator (DrawX/DrawY) and the VGA DAC; 2-cycle registered pipeline.
// PARAMETERS
//  NUM_TRACKS   4    rows (tracks) in grid
//  NUM_STEPS    16   columns (steps) per track
//  CELL_LOG2    5    cell edge = 2**CELL_LOG2 pixels (32)
//  GRID_X0      64   left pixel of grid
//  GRID_Y0      160  top pixel of grid
//  FLASH_FRAMES 8    frames a track stays lit after a hit
// PORTS
//  Clk          in   1                     pixel clock
//  Reset_n      in   1                     asynchronous, active-low reset
//  DrawX        in   10                    current pixel column
//  DrawY        in   10                    current pixel row
//  pix_valid    in   1                     DrawX/DrawY in active video
//  frame_start  in   1                     one-cycle pulse at start of each frame
//  pattern      in   NUM_TRACKS*NUM_STEPS  step on bits; bit index = track*NUM_STEPS+step
//  play_step    in   $clog2(NUM_STEPS)     current playhead column
//  cursor_track in   $clog2(NUM_TRACKS)    edit cursor row
//  cursor_step  in   $clog2(NUM_STEPS)     edit cursor column
//  hit          in   NUM_TRACKS            one-cycle trigger pulse per track
//  Red/Green/Blue out 8 each               registered pixel colour
//  rgb_valid    out  1                     pix_valid delayed 2 cycles
// BEHAVIOUR
//  - Reset: Red/Green/Blue=0, rgb_valid=0, all flash counters=0, pipeline regs cleared.
//  - Latency exactly 2 Clk from DrawX/DrawY/pix_valid to RGB/rgb_valid; one pixel per cycle, no stalls.
//  - Stage 1 (reg): rx=DrawX-GRID_X0, ry=DrawY-GRID_Y0 (11-bit, unsigned compare, no signed mult);
//    in_grid = DrawX>=GRID_X0 && ry-range similarly && rx>>CELL_LOG2 < NUM_STEPS && ry>>CELL_LOG2 < NUM_TRACKS;
//    step=rx>>CELL_LOG2, track=ry>>CELL_LOG2, border = rx[CELL_LOG2-1:0]==0 || ry[CELL_LOG2-1:0]==0.
//    cursor_edge = cell==cursor && any low bits of rx/ry equal 1 or 2**CELL_LOG2-1. Also carry DrawX[9:3], pix_valid.
//  - Stage 2 (reg): priority, highest first:
//    !pix_valid -> 000000; !in_grid -> R=0,G=0,B=8'h7F-DrawX[9:3]; border -> 000000;
//    cursor_edge -> FF00FF; flash[track]!=0 && pattern bit -> 00FF00;
//    step==play_step && pattern bit -> FFFF00; pattern bit -> FF5500;
//    step==play_step -> 404080; else 202020.
//  - Flash counter per track (width $clog2(FLASH_FRAMES+1)): hit -> load FLASH_FRAMES;
//    frame_start && cnt!=0 -> cnt-1; hit and frame_start same cycle -> load wins; saturates at 0.
//  - pattern/play_step/cursor sampled in stage 2 live (may change mid-frame; tearing acceptable).
//  - play_step >= NUM_STEPS or cursor out of range -> never matches any cell, no highlight.
//  - Reset asserted mid-frame: outputs black immediately (async), resume after 2 cycles post-release.
// STRUCTURE
//  - Package seq_video_pkg: rgb_t struct {r,g,b}, colour constants (COL_ON, COL_OFF, COL_PLAY_ON,
//    COL_PLAY_OFF, COL_FLASH, COL_CURSOR, COL_BORDER), BG_BLUE_BASE=8'h7F.
//  - Sub-module seq_flash_timer (one counter: Clk, Reset_n, hit, frame_start, active), generate-instanced NUM_TRACKS times.
//  - Top: two always_ff pipeline stages + one always_comb colour priority mux.
// TESTING
//  1. Reset held, random DrawX/Y -> RGB=0, rgb_valid=0; release -> first valid output 2 cycles after pix_valid.
//  2. pattern bit 19 set, DrawX=170,DrawY=202 (track1 step3), play_step=0 -> FF5500 at cycle+2; bit clear -> 202020.
//  3. Same pixel, play_step=3 -> FFFF00 (on) / 404080 (off); play_step=20 -> no playhead colour.
//  4. DrawX=160,DrawY=202 (cell border) -> 000000; DrawX=40,DrawY=100 -> B=7F-5=7A, R=G=0.
//  5. hit[1] pulse, bit 19 set -> 00FF00 for 8 frame_start pulses, FF5500 after 8th; hit with frame_start same cycle -> count=8.
//  6. cursor=(1,3), DrawX=161,DrawY=202 -> FF00FF; DrawX=170,DrawY=202 (interior) -> cell colour, not cursor.

Source files
------------

// File: rtl/seq_video_pkg.sv
// Shared pixel-colour types and palette for the step-sequencer grid display.
package seq_video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t COL_BLACK    = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t COL_BORDER   = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t COL_ON       = '{r: 8'hFF, g: 8'h55, b: 8'h00};
    localparam rgb_t COL_OFF      = '{r: 8'h20, g: 8'h20, b: 8'h20};
    localparam rgb_t COL_PLAY_ON  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t COL_PLAY_OFF = '{r: 8'h40, g: 8'h40, b: 8'h80};
    localparam rgb_t COL_FLASH    = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t COL_CURSOR   = '{r: 8'hFF, g: 8'h00, b: 8'hFF};

    localparam logic [7:0] BG_BLUE_BASE = 8'h7F;

    // Background fades from blue on the left to black on the right, one step per 8 pixels.
    function automatic rgb_t bg_colour(input logic [6:0] coarse_x);
        rgb_t c;
        c.r = 8'h00;
        c.g = 8'h00;
        c.b = BG_BLUE_BASE - {1'b0, coarse_x};
        return c;
    endfunction

endpackage

// File: rtl/seq_flash_timer.sv
// Per-track hit flash: reloads on a hit, then counts down once per frame until idle.
module seq_flash_timer #(
    parameter int FLASH_FRAMES = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic hit,
    input  logic frame_start,
    output logic active
);

    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Next count: a hit always reloads, even when it coincides with a frame tick.
    always_comb begin
        cnt_next_s = cnt_r;
        if (hit) begin
            cnt_next_s = CNT_W'(FLASH_FRAMES);
        end else if (frame_start && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_next_s = cnt_r - CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter and its registered non-zero flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            active <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            active <= (cnt_next_s != {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/seq_grid_mapper.sv
// Step-sequencer grid pixel colour generator: two-stage pipeline from DrawX/DrawY to RGB.
module seq_grid_mapper
    import seq_video_pkg::*;
#(
    parameter int NUM_TRACKS   = 4,
    parameter int NUM_STEPS    = 16,
    parameter int CELL_LOG2    = 5,
    parameter int GRID_X0      = 64,
    parameter int GRID_Y0      = 160,
    parameter int FLASH_FRAMES = 8
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    input  logic                             pix_valid,
    input  logic                             frame_start,
    input  logic [NUM_TRACKS*NUM_STEPS-1:0]  pattern,
    input  logic [$clog2(NUM_STEPS)-1:0]     play_step,
    input  logic [$clog2(NUM_TRACKS)-1:0]    cursor_track,
    input  logic [$clog2(NUM_STEPS)-1:0]     cursor_step,
    input  logic [NUM_TRACKS-1:0]            hit,
    output logic [7:0]                       Red,
    output logic [7:0]                       Green,
    output logic [7:0]                       Blue,
    output logic                             rgb_valid
);

    localparam int STEP_W  = $clog2(NUM_STEPS);
    localparam int TRACK_W = $clog2(NUM_TRACKS);
    localparam int BIT_W   = $clog2(NUM_TRACKS * NUM_STEPS);

    logic [10:0]        rx_s;
    logic [10:0]        ry_s;
    logic [10:0]        col_s;
    logic [10:0]        row_s;
    logic               in_grid_s;
    logic               border_s;
    logic               edge_band_s;

    logic               valid1_r;
    logic               in_grid_r;
    logic               border_r;
    logic               edge_band_r;
    logic [STEP_W-1:0]  step_r;
    logic [TRACK_W-1:0] track_r;
    logic [6:0]         coarse_x_r;

    logic [NUM_TRACKS-1:0] flash_s;
    logic [BIT_W-1:0]      bit_idx_s;
    logic                  step_on_s;
    logic                  play_hit_s;
    logic                  cursor_hit_s;
    rgb_t                  colour_s;

    genvar t;
    generate
        for (t = 0; t < NUM_TRACKS; t++) begin : g_flash
            seq_flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
                .Clk         (Clk),
                .Reset_n     (Reset_n),
                .hit         (hit[t]),
                .frame_start (frame_start),
                .active      (flash_s[t])
            );
        end
    endgenerate

    // Grid-relative coordinates; pixels left of / above the grid wrap high and are rejected explicitly.
    always_comb begin
        rx_s        = {1'b0, DrawX} - 11'(GRID_X0);
        ry_s        = {1'b0, DrawY} - 11'(GRID_Y0);
        col_s       = rx_s >> CELL_LOG2;
        row_s       = ry_s >> CELL_LOG2;
        in_grid_s   = ({1'b0, DrawX} >= 11'(GRID_X0)) && ({1'b0, DrawY} >= 11'(GRID_Y0)) &&
                      (col_s < 11'(NUM_STEPS)) && (row_s < 11'(NUM_TRACKS));
        border_s    = (rx_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}}) ||
                      (ry_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b0}});
        edge_band_s = (rx_s[CELL_LOG2-1:0] == CELL_LOG2'(1)) ||
                      (rx_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b1}}) ||
                      (ry_s[CELL_LOG2-1:0] == CELL_LOG2'(1)) ||
                      (ry_s[CELL_LOG2-1:0] == {CELL_LOG2{1'b1}});
    end

    // Stage 1: geometry classification of the current pixel.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid1_r    <= 1'b0;
            in_grid_r   <= 1'b0;
            border_r    <= 1'b0;
            edge_band_r <= 1'b0;
            step_r      <= {STEP_W{1'b0}};
            track_r     <= {TRACK_W{1'b0}};
            coarse_x_r  <= 7'd0;
        end else begin
            valid1_r    <= pix_valid;
            in_grid_r   <= in_grid_s;
            border_r    <= border_s;
            edge_band_r <= edge_band_s;
            step_r      <= col_s[STEP_W-1:0];
            track_r     <= row_s[TRACK_W-1:0];
            coarse_x_r  <= DrawX[9:3];
        end
    end

    // Cell state lookups use the live pattern, playhead and cursor; out-of-range positions never match.
    always_comb begin
        bit_idx_s    = BIT_W'(track_r) * BIT_W'(NUM_STEPS) + BIT_W'(step_r);
        step_on_s    = pattern[bit_idx_s];
        play_hit_s   = (32'(play_step) < NUM_STEPS) && (step_r == play_step);
        cursor_hit_s = edge_band_r &&
                       (32'(cursor_step) < NUM_STEPS) && (32'(cursor_track) < NUM_TRACKS) &&
                       (step_r == cursor_step) && (track_r == cursor_track);
    end

    // Colour priority, highest first.
    always_comb begin
        colour_s = COL_BLACK;
        if (!valid1_r) begin
            colour_s = COL_BLACK;
        end else if (!in_grid_r) begin
            colour_s = bg_colour(coarse_x_r);
        end else if (border_r) begin
            colour_s = COL_BORDER;
        end else if (cursor_hit_s) begin
            colour_s = COL_CURSOR;
        end else if (flash_s[track_r] && step_on_s) begin
            colour_s = COL_FLASH;
        end else if (play_hit_s && step_on_s) begin
            colour_s = COL_PLAY_ON;
        end else if (step_on_s) begin
            colour_s = COL_ON;
        end else if (play_hit_s) begin
            colour_s = COL_PLAY_OFF;
        end else begin
            colour_s = COL_OFF;
        end
    end

    // Stage 2: registered colour output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Red       <= 8'h00;
            Green     <= 8'h00;
            Blue      <= 8'h00;
            rgb_valid <= 1'b0;
        end else begin
            Red       <= colour_s.r;
            Green     <= colour_s.g;
            Blue      <= colour_s.b;
            rgb_valid <= valid1_r;
        end
    end

endmodule

// File: tb/tb_seq_grid_mapper.sv
// Self-checking bench for seq_grid_mapper: behavioural pixel model plus directed literal checks.
module tb_seq_grid_mapper;

    logic        clk;
    logic        rst_n;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic        pix_valid;
    logic        frame_start;
    logic [63:0] pattern;
    logic [3:0]  play_step;
    logic [1:0]  cursor_track;
    logic [3:0]  cursor_step;
    logic [3:0]  hit;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        rgb_valid;

    seq_grid_mapper dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .DrawX        (draw_x),
        .DrawY        (draw_y),
        .pix_valid    (pix_valid),
        .frame_start  (frame_start),
        .pattern      (pattern),
        .play_step    (play_step),
        .cursor_track (cursor_track),
        .cursor_step  (cursor_step),
        .hit          (hit),
        .Red          (red),
        .Green        (green),
        .Blue         (blue),
        .rgb_valid    (rgb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    bit cmp_on   = 1'b0;

    logic [24:0] lit_exp = 25'd0;
    string       lit_name = "";
    int          lit_seq  = 0;
    int          lit_done = 0;

    // Model state: {valid, R, G, B} expected now; pixel captured last edge; flash counts per track.
    logic [24:0] exp_out;
    int          p_x, p_y;
    bit          p_v;
    int          fcnt [4];
    logic [3:0]  fl_mask;

    function automatic logic [24:0] model_px(input int x, input int y, input bit v,
                                             input logic [63:0] pat, input int play,
                                             input int ct, input int cs, input logic [3:0] fl);
        int cx, cy, ox, oy;
        bit on;
        if (!v) return 25'd0;
        if (x < 64 || x >= 64 + 16 * 32 || y < 160 || y >= 160 + 4 * 32)
            return {1'b1, 16'h0000, 8'(127 - x / 8)};
        cx = (x - 64) / 32;
        cy = (y - 160) / 32;
        ox = (x - 64) % 32;
        oy = (y - 160) % 32;
        if (ox == 0 || oy == 0) return {1'b1, 24'h000000};
        if (cx == cs && cy == ct && (ox == 1 || ox == 31 || oy == 1 || oy == 31))
            return {1'b1, 24'hFF00FF};
        on = pat[cy * 16 + cx];
        if (fl[cy] && on) return {1'b1, 24'h00FF00};
        if (cx == play && on) return {1'b1, 24'hFFFF00};
        if (on) return {1'b1, 24'hFF5500};
        if (cx == play) return {1'b1, 24'h404080};
        return {1'b1, 24'h202020};
    endfunction

    always_comb begin
        fl_mask = 4'b0000;
        for (int t = 0; t < 4; t++) fl_mask[t] = (fcnt[t] != 0);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out <= 25'd0;
            p_x     <= 0;
            p_y     <= 0;
            p_v     <= 1'b0;
            for (int t = 0; t < 4; t++) fcnt[t] <= 0;
        end else begin
            exp_out <= model_px(p_x, p_y, p_v, pattern, int'(play_step),
                                int'(cursor_track), int'(cursor_step), fl_mask);
            p_x <= int'(draw_x);
            p_y <= int'(draw_y);
            p_v <= pix_valid;
            for (int t = 0; t < 4; t++) begin
                if (hit[t]) fcnt[t] <= 8;
                else if (frame_start && fcnt[t] > 0) fcnt[t] <= fcnt[t] - 1;
            end
        end
    end

    // Single compare process: model check every cycle, plus any pending literal expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                n_checks++;
                if ({rgb_valid, red, green, blue} !== exp_out) begin
                    n_bad++;
                    $display("FAIL pixel t=%0t got=%h expected=%h", $time,
                             {rgb_valid, red, green, blue}, exp_out);
                end
                if (lit_seq != lit_done) begin
                    lit_done = lit_seq;
                    n_checks++;
                    if ({rgb_valid, red, green, blue} !== lit_exp) begin
                        n_bad++;
                        $display("FAIL %s got=%h expected=%h", lit_name,
                                 {rgb_valid, red, green, blue}, lit_exp);
                    end
                end
            end
        end
    end

    task automatic lit(input logic [24:0] e, input string nm);
        lit_exp  = e;
        lit_name = nm;
        lit_seq++;
    endtask

    task automatic show(input int x, input int y, input bit v, input logic [23:0] e, input string nm);
        @(negedge clk);
        draw_x    = 10'(x);
        draw_y    = 10'(y);
        pix_valid = v;
        @(posedge clk);
        @(posedge clk);
        #1;
        lit({v, e}, nm);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] h, input bit fs);
        @(negedge clk);
        hit         = h;
        frame_start = fs;
        @(negedge clk);
        hit         = 4'b0000;
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        draw_x       = 10'd0;
        draw_y       = 10'd0;
        pix_valid    = 1'b0;
        frame_start  = 1'b0;
        pattern      = 64'd0;
        play_step    = 4'd0;
        cursor_track = 2'd3;
        cursor_step  = 4'd15;
        hit          = 4'b0000;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;

        // Reset held with live pixels: output must stay black and invalid.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            draw_x    = 10'($urandom_range(0, 639));
            draw_y    = 10'($urandom_range(0, 479));
            pix_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        lit(25'd0, "reset_hold");
        @(negedge clk);
        rst_n      = 1'b1;
        draw_x     = 10'd170;
        draw_y     = 10'd202;
        pattern[19] = 1'b1;
        @(posedge clk);
        #1;
        lit(25'd0, "release_lat1");
        @(posedge clk);
        #1;
        lit({1'b1, 24'hFF5500}, "release_lat2");
        @(negedge clk);

        // Track 1 step 3 cell, on/off, with and without playhead.
        show(170, 202, 1'b1, 24'hFF5500, "cell_on");
        pattern[19] = 1'b0;
        show(170, 202, 1'b1, 24'h202020, "cell_off");
        play_step = 4'd3;
        show(170, 202, 1'b1, 24'h404080, "play_off");
        pattern[19] = 1'b1;
        show(170, 202, 1'b1, 24'hFFFF00, "play_on");
        play_step = 4'd15;
        show(170, 202, 1'b1, 24'hFF5500, "play_elsewhere");
        show(170, 202, 1'b0, 24'h000000, "pix_invalid");

        // Borders and background edges.
        show(160, 202, 1'b1, 24'h000000, "border_x");
        show(170, 192, 1'b1, 24'h000000, "border_y");
        show(40, 100, 1'b1, 24'h00007A, "bg_left");
        show(576, 202, 1'b1, 24'h000037, "bg_right");
        show(170, 288, 1'b1, 24'h00006A, "bg_below");
        show(575, 287, 1'b1, 24'hFF00FF, "cursor_corner");

        // Flash: 8 frames lit after a hit, reload wins over a same-cycle frame tick.
        play_step = 4'd0;
        pulse(4'b0010, 1'b0);
        show(170, 202, 1'b1, 24'h00FF00, "flash_on");
        for (int i = 1; i <= 8; i++) begin
            pulse(4'b0000, 1'b1);
            show(170, 202, 1'b1, (i < 8) ? 24'h00FF00 : 24'hFF5500, "flash_decay");
        end
        pulse(4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) pulse(4'b0000, 1'b1);
        pulse(4'b0010, 1'b1);
        for (int i = 1; i <= 7; i++) pulse(4'b0000, 1'b1);
        show(170, 202, 1'b1, 24'h00FF00, "flash_reload_7");
        pulse(4'b0000, 1'b1);
        show(170, 202, 1'b1, 24'hFF5500, "flash_reload_8");
        pulse(4'b0001, 1'b0);
        show(170, 202, 1'b1, 24'hFF5500, "flash_other_track");

        // Cursor outline on cell (1,3).
        cursor_track = 2'd1;
        cursor_step  = 4'd3;
        show(161, 202, 1'b1, 24'hFF00FF, "cursor_left");
        show(191, 202, 1'b1, 24'hFF00FF, "cursor_right");
        show(170, 193, 1'b1, 24'hFF00FF, "cursor_top");
        show(170, 202, 1'b1, 24'hFF5500, "cursor_interior");

        // Asynchronous reset mid-frame blanks the output before the next edge.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        lit(25'd0, "async_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Random sweep checked by the model every cycle.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            draw_x    = 10'($urandom_range(30, 620));
            draw_y    = 10'($urandom_range(140, 300));
            pix_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) pattern = {$urandom, $urandom};
            play_step = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) begin
                cursor_track = 2'($urandom_range(0, 3));
                cursor_step  = 4'($urandom_range(0, 15));
            end
            hit         = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
            frame_start = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        hit         = 4'b0000;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
